// File: rtl/mem_pkg.sv
// Shared helpers for the banked byte-enable buffer: width helpers and the byte-merge function.
package mem_pkg;

    // Upper bound for the width-generic merge helper; callers zero-extend into it.
    localparam int MAX_WIDTH = 1024;
    localparam int MAX_BE    = MAX_WIDTH / 8;

    function automatic int bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Index widths never collapse to zero bits, even for a single bank or row.
    function automatic int sel_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int row_w(input int length, input int num_banks);
        return ((length / num_banks) > 1) ? $clog2(length / num_banks) : 1;
    endfunction

    function automatic int be_w(input int width);
        return width / 8;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] be_merge(
        input logic [MAX_WIDTH-1:0] old_w,
        input logic [MAX_WIDTH-1:0] new_w,
        input logic [MAX_BE-1:0]    be
    );
        logic [MAX_WIDTH-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BE; i++)
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One interleaved bank: simple dual-port array, byte-enable write, registered read, no reset.
module mem_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_row,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_row,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Same-row read and write return the old word; the top level handles write-first merging.
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < WIDTH/8; i++)
                if (wr_be[i]) mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
        if (rd_en)
            rd_data <= mem[rd_row];
    end

endmodule

// File: rtl/mem_banked_be.sv
// Banked byte-enable buffer: address decode, range check, collision merge and read-latency pipeline.
module mem_banked_be
    import mem_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int LENGTH      = 4096,
    parameter int NUM_BANKS   = 4,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [31:0]        wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    output logic               wr_err,
    input  logic               rd_en,
    input  logic [31:0]        rd_addr,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_err
);

    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int SEL_W  = sel_w(NUM_BANKS);
    localparam int DEPTH  = LENGTH / NUM_BANKS;
    localparam int ROW_W  = row_w(LENGTH, NUM_BANKS);
    localparam int BE_W   = be_w(WIDTH);

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WIDTH-1:0] data;
    } rd_pipe_t;

    if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("mem_banked_be: WIDTH must be a multiple of 8 in 8..%0d", MAX_WIDTH);
    end
    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $error("mem_banked_be: NUM_BANKS must be a power of two >= 1");
    end
    if (LENGTH < NUM_BANKS || LENGTH % NUM_BANKS != 0) begin : g_bad_length
        $error("mem_banked_be: LENGTH must be a non-zero multiple of NUM_BANKS");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("mem_banked_be: RD_LATENCY must be 1..4");
    end

    logic             wr_in_range, rd_in_range;
    logic             wr_ok, rd_ok, coll;
    logic [SEL_W-1:0] wr_bank, rd_bank;
    logic [ROW_W-1:0] wr_row, rd_row;

    assign wr_in_range = wr_addr < 32'(LENGTH);
    assign rd_in_range = rd_addr < 32'(LENGTH);
    // Banks have no reset, so requests seen during reset must be blocked here.
    assign wr_ok = wr_en && wr_in_range && !rst;
    assign rd_ok = rd_en && rd_in_range && !rst;
    assign coll  = wr_ok && rd_ok && (wr_addr == rd_addr);

    assign wr_bank = SEL_W'(wr_addr & 32'(NUM_BANKS - 1));
    assign rd_bank = SEL_W'(rd_addr & 32'(NUM_BANKS - 1));
    assign wr_row  = ROW_W'(wr_addr >> BANK_W);
    assign rd_row  = ROW_W'(rd_addr >> BANK_W);

    logic [NUM_BANKS-1:0][WIDTH-1:0] bank_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (ROW_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_ok && (wr_bank == SEL_W'(b))),
            .wr_row  (wr_row),
            .wr_data (wr_data),
            .wr_be   (wr_be),
            .rd_en   (rd_ok && (rd_bank == SEL_W'(b))),
            .rd_row  (rd_row),
            .rd_data (bank_q[b])
        );
    end

    // Side information captured alongside the bank read at the issue edge.
    logic             rd_issued;
    logic             s0_err, s0_coll;
    logic [SEL_W-1:0] s0_bank;
    logic [WIDTH-1:0] s0_wdata;
    logic [BE_W-1:0]  s0_wbe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_issued <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            rd_issued <= rd_en;
            wr_err    <= wr_en && !wr_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            s0_err   <= !rd_in_range;
            s0_bank  <= rd_bank;
            s0_coll  <= coll;
            s0_wdata <= wr_data;
            s0_wbe   <= wr_be;
        end
    end

    rd_pipe_t s1;
    rd_pipe_t pipe_d [1:RD_LATENCY];
    rd_pipe_t pipe_q [1:RD_LATENCY];

    always_comb begin
        s1.valid = rd_issued;
        s1.err   = s0_err;
        s1.data  = bank_q[s0_bank];
        if (WRITE_FIRST != 0 && s0_coll)
            s1.data = WIDTH'(be_merge(MAX_WIDTH'(bank_q[s0_bank]), MAX_WIDTH'(s0_wdata),
                                      MAX_BE'(s0_wbe)));
        if (s0_err)
            s1.data = '0;
        pipe_d[1] = s1;
        for (int k = 2; k <= RD_LATENCY; k++)
            pipe_d[k] = pipe_q[k-1];
    end

    // Last stage only loads on a valid read so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= RD_LATENCY; k++)
                pipe_q[k].valid <= 1'b0;
            pipe_q[RD_LATENCY].err  <= 1'b0;
            pipe_q[RD_LATENCY].data <= '0;
        end else begin
            for (int k = 1; k < RD_LATENCY; k++)
                pipe_q[k] <= pipe_d[k];
            pipe_q[RD_LATENCY].valid <= pipe_d[RD_LATENCY].valid;
            if (pipe_d[RD_LATENCY].valid) begin
                pipe_q[RD_LATENCY].err  <= pipe_d[RD_LATENCY].err;
                pipe_q[RD_LATENCY].data <= pipe_d[RD_LATENCY].data;
            end
        end
    end

    assign rd_valid = pipe_q[RD_LATENCY].valid;
    assign rd_err   = pipe_q[RD_LATENCY].valid && pipe_q[RD_LATENCY].err;
    assign rd_data  = pipe_q[RD_LATENCY].data;

endmodule

// File: tb/tb_mem_banked_be.sv
// Scoreboard bench: three buffer configurations share one directed stimulus stream.
module tb_mem_banked_be;

    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};
    localparam bit WF  [N] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_be = '0;

    logic        wre [N];
    logic        rdv [N];
    logic        rde [N];
    logic [63:0] rdd [N];

    exp_t sbq [N][$];
    int   wq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_banked_be #(.WIDTH(64), .LENGTH(4096), .NUM_BANKS(4), .RD_LATENCY(1), .WRITE_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_err(wre[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rdv[0]), .rd_data(rdd[0]),
        .rd_err(rde[0]));
    mem_banked_be #(.WIDTH(64), .LENGTH(4096), .NUM_BANKS(4), .RD_LATENCY(3), .WRITE_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_err(wre[1]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rdv[1]), .rd_data(rdd[1]),
        .rd_err(rde[1]));
    mem_banked_be #(.WIDTH(64), .LENGTH(4096), .NUM_BANKS(2), .RD_LATENCY(4), .WRITE_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_err(wre[2]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rdv[2]), .rd_data(rdd[2]),
        .rd_err(rde[2]));

    function automatic void chk(input string name, input int inst, input logic [63:0] got,
                                input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", name, inst, cyc, got, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever an entry falls due and compares the DUT outputs.
    always @(negedge clk) begin : mon
        exp_t e;
        logic due_now, wdue;
        wdue = (wq.size() != 0) && (wq[0] <= cyc);
        if (wdue) void'(wq.pop_front());
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                chk("rst_rd_valid", i, 64'(rdv[i]), 64'd0);
                chk("rst_rd_data", i, rdd[i], 64'd0);
                chk("rst_rd_err", i, 64'(rde[i]), 64'd0);
                chk("rst_wr_err", i, 64'(wre[i]), 64'd0);
            end else begin
                chk("wr_err", i, 64'(wre[i]), 64'(wdue));
                due_now = (sbq[i].size() != 0) && (sbq[i][0].due <= cyc);
                chk("rd_valid", i, 64'(rdv[i]), 64'(due_now));
                if (due_now) begin
                    e = sbq[i].pop_front();
                    if (rdv[i]) begin
                        chk("rd_data", i, rdd[i], e.data);
                        chk("rd_err", i, 64'(rde[i]), 64'(e.err));
                    end
                end else begin
                    chk("rd_err_idle", i, 64'(rde[i]), 64'd0);
                end
            end
        end
    end

    // e_wf1/e_wf0: hand-computed read data for write-first and read-first instances.
    task automatic step(input logic we, input logic [31:0] wa, input logic [63:0] wd,
                        input logic [7:0] wbe, input logic re, input logic [31:0] ra,
                        input logic [63:0] e_wf1, input logic [63:0] e_wf0);
        exp_t e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra;
        if (!rst && we && wa >= 32'd4096) wq.push_back(cyc + 1);
        if (!rst && re) begin
            for (int i = 0; i < N; i++) begin
                e.due  = cyc + 1 + LAT[i];
                e.err  = (ra >= 32'd4096);
                e.data = WF[i] ? e_wf1 : e_wf0;
                sbq[i].push_back(e);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        step(1'b1, a, d, be, 1'b0, 32'd0, 64'd0, 64'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] exp);
        step(1'b0, 32'd0, 64'd0, 8'd0, 1'b1, a, exp, exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 64'd0, 8'd0, 1'b0, 32'd0, 64'd0, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic write/read and byte-enable partial write
        wr(32'd5, 64'h1122334455667788, 8'hFF);
        rd(32'd5, 64'h1122334455667788);
        wr(32'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        rd(32'd5, 64'h11223344FFFFFFFF);

        // Concurrent read/write to a different bank (6) and to the same bank (13)
        step(1'b1, 32'd6, 64'h0102030405060708, 8'hFF, 1'b1, 32'd5,
             64'h11223344FFFFFFFF, 64'h11223344FFFFFFFF);
        step(1'b1, 32'd13, 64'hCAFEF00D12345678, 8'hFF, 1'b1, 32'd5,
             64'h11223344FFFFFFFF, 64'h11223344FFFFFFFF);
        rd(32'd6, 64'h0102030405060708);
        rd(32'd13, 64'hCAFEF00D12345678);

        // Same-edge collision
        wr(32'd9, 64'd0, 8'hFF);
        step(1'b1, 32'd9, 64'hAAAAAAAAAAAAAAAA, 8'hF0, 1'b1, 32'd9,
             64'hAAAAAAAA00000000, 64'h0000000000000000);
        rd(32'd9, 64'hAAAAAAAA00000000);

        // wr_be=0 is a no-op
        wr(32'd6, 64'h9999999999999999, 8'h00);
        rd(32'd6, 64'h0102030405060708);

        // Out-of-range writes (4096 aliases @0 if truncated) and reads
        wr(32'd0, 64'hDEADBEEF00C0FFEE, 8'hFF);
        step(1'b1, 32'd4096, 64'h5555555555555555, 8'hFF, 1'b1, 32'd0,
             64'hDEADBEEF00C0FFEE, 64'hDEADBEEF00C0FFEE);
        rd(32'd0, 64'hDEADBEEF00C0FFEE);
        wr(32'hFFFFFFFF, 64'h6666666666666666, 8'hFF);
        rd(32'd5000, 64'd0);
        rd(32'd4096, 64'd0);
        idle(2);

        // Streaming: preload addr*3, then 16 back-to-back reads; a later write to 7 must not leak
        for (int a = 0; a < 16; a++) wr(32'(a), 64'(a * 3), 8'hFF);
        for (int a = 0; a < 16; a++) begin
            if (a == 8)
                step(1'b1, 32'd7, 64'h7777777777777777, 8'hFF, 1'b1, 32'd8, 64'd24, 64'd24);
            else
                rd(32'(a), 64'(a * 3));
        end
        idle(6);
        rd(32'd7, 64'h7777777777777777);
        idle(6);

        // Reset with reads in flight; requests during reset are ignored
        rd(32'd1, 64'd3);
        rd(32'd2, 64'd6);
        rd(32'd3, 64'd9);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) sbq[i].delete();
        wq.delete();
        step(1'b1, 32'd5, 64'hBADBADBADBADBAD0, 8'hFF, 1'b1, 32'd5, 64'd0, 64'd0);
        idle(2);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b0;
        rd(32'd5, 64'd15);
        rd(32'd1, 64'd3);
        rd(32'd7, 64'h7777777777777777);
        rd(32'd9, 64'd27);
        idle(8);

        for (int i = 0; i < N; i++) chk("drain", i, 64'(sbq[i].size()), 64'd0);
        chk("wr_err_drain", 0, 64'(wq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
